// File: rtl/g2b_pkg.sv
// Shared types and constants for the G2B job scheduler: FSM states, processing
// mode codes and the latched job descriptor.
package g2b_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [7:0] MODE_PASS   = 8'h00;
   localparam logic [7:0] MODE_ADD    = 8'h01;
   localparam logic [7:0] MODE_SUB    = 8'h02;
   localparam logic [7:0] MODE_XOR    = 8'h03;
   localparam logic [7:0] MODE_SHL    = 8'h04;
   localparam logic [7:0] MODE_SHR    = 8'h05;
   localparam logic [7:0] MODE_BYPASS = 8'hFF;

   // len and base are held at 32 bits so the struct is independent of the
   // scheduler's LEN_WIDTH / ADDR_WIDTH parameters.
   typedef struct packed {
      logic [7:0]  mode;
      logic [31:0] param;
      logic [31:0] len;
      logic [31:0] base;
   } job_t;

endpackage

// File: rtl/g2b_job_scheduler_if.sv
// Bundle of job, source, processor and BRAM signals around the scheduler.
// slave = scheduler side, master = requester/processor/BRAM side.
interface g2b_job_scheduler_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 11,
   parameter int LEN_WIDTH  = 12
);
   logic [NUM_REQ-1:0]                 i_job_valid;
   logic [NUM_REQ-1:0]                 o_job_ready;
   logic [NUM_REQ-1:0][7:0]            i_job_mode;
   logic [NUM_REQ-1:0][31:0]           i_job_param;
   logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  i_job_len;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] i_job_base;
   logic [NUM_REQ-1:0]                 o_job_done;

   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_src_data;
   logic [NUM_REQ-1:0]                 i_src_valid;
   logic [NUM_REQ-1:0]                 o_src_ready;

   logic [DATA_WIDTH-1:0]              o_proc_data;
   logic                               o_proc_valid;
   logic                               i_proc_ready;
   logic [31:0]                        o_proc_mode;
   logic [31:0]                        o_proc_param;

   logic [DATA_WIDTH-1:0]              i_proc_data;
   logic                               i_proc_valid;
   logic                               o_proc_ready;

   logic                               o_bram_we;
   logic [ADDR_WIDTH-1:0]              o_bram_addr;
   logic [DATA_WIDTH-1:0]              o_bram_wdata;

   modport slave (
      input  i_job_valid, i_job_mode, i_job_param, i_job_len, i_job_base,
      input  i_src_data, i_src_valid, i_proc_ready, i_proc_data, i_proc_valid,
      output o_job_ready, o_job_done, o_src_ready,
      output o_proc_data, o_proc_valid, o_proc_mode, o_proc_param, o_proc_ready,
      output o_bram_we, o_bram_addr, o_bram_wdata
   );

   modport master (
      output i_job_valid, i_job_mode, i_job_param, i_job_len, i_job_base,
      output i_src_data, i_src_valid, i_proc_ready, i_proc_data, i_proc_valid,
      input  o_job_ready, o_job_done, o_src_ready,
      input  o_proc_data, o_proc_valid, o_proc_mode, o_proc_param, o_proc_ready,
      input  o_bram_we, o_bram_addr, o_bram_wdata
   );
endinterface

// File: rtl/g2b_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after ptr,
// as a one-hot vector plus its binary index.
module g2b_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PTR_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   logic [PTR_W-1:0] cand;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment; a missed path would otherwise infer a latch.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
         if (!gnt_any && req[cand]) begin
            gnt_any   = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/g2b_job_scheduler.sv
// Job scheduler: round-robin grants one requester at a time, streams its beats
// through the processor and writes the results to consecutive BRAM words.
module g2b_job_scheduler
   import g2b_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 11,
   parameter int LEN_WIDTH  = 12
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   g2b_job_scheduler_if.slave bus
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t                state_q, state_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]      gnt_q, gnt_d;
   job_t                  job_q, job_d;
   logic [LEN_WIDTH-1:0]  in_cnt_q, in_cnt_d;
   logic [LEN_WIDTH-1:0]  out_cnt_q, out_cnt_d;
   logic [NUM_REQ-1:0]    ready_q, ready_d;
   logic [NUM_REQ-1:0]    done_q, done_d;
   logic                  bram_we_q, bram_we_d;
   logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
   logic [DATA_WIDTH-1:0] bram_wdata_q, bram_wdata_d;

   logic [NUM_REQ-1:0]    arb_gnt;
   logic [PTR_W-1:0]      arb_idx;
   logic                  arb_any;

   g2b_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req     (bus.i_job_valid),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   always_comb begin
      state_d          = state_q;
      rr_ptr_d         = rr_ptr_q;
      gnt_d            = gnt_q;
      job_d            = job_q;
      in_cnt_d         = in_cnt_q;
      out_cnt_d        = out_cnt_q;
      ready_d          = '0;
      done_d           = '0;
      bram_we_d        = 1'b0;
      bram_addr_d      = bram_addr_q;
      bram_wdata_d     = bram_wdata_q;
      bus.o_proc_valid = 1'b0;
      bus.o_proc_data  = '0;
      bus.o_src_ready  = '0;

      // Results may arrive while input is still streaming, and after it ends.
      if ((state_q == ST_RUN || state_q == ST_DRAIN) && bus.i_proc_valid) begin
         bram_we_d    = 1'b1;
         bram_addr_d  = ADDR_WIDTH'(job_q.base + 32'(out_cnt_q));
         bram_wdata_d = bus.i_proc_data;
         out_cnt_d    = out_cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               gnt_d       = arb_idx;
               ready_d     = arb_gnt;
               rr_ptr_d    = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
               job_d.mode  = bus.i_job_mode[arb_idx];
               job_d.param = bus.i_job_param[arb_idx];
               job_d.len   = 32'(bus.i_job_len[arb_idx]);
               job_d.base  = 32'(bus.i_job_base[arb_idx]);
               state_d     = (bus.i_job_len[arb_idx] == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            bus.o_proc_valid        = bus.i_src_valid[gnt_q];
            bus.o_proc_data         = bus.i_src_data[gnt_q];
            bus.o_src_ready[gnt_q]  = bus.i_proc_ready;
            if (bus.i_src_valid[gnt_q] && bus.i_proc_ready) begin
               in_cnt_d = in_cnt_q + 1'b1;
               if (32'(in_cnt_d) == job_q.len) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (32'(out_cnt_d) == job_q.len) state_d = ST_DONE;
         end
         ST_DONE: begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_DONE) done_d[gnt_d] = 1'b1;
   end

   // NOTE: registers take non-blocking assignments so every flop samples the
   // pre-edge value of every other flop, independent of block ordering.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         gnt_q        <= '0;
         job_q        <= '0;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         ready_q      <= '0;
         done_q       <= '0;
         bram_we_q    <= 1'b0;
         bram_addr_q  <= '0;
         bram_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         gnt_q        <= gnt_d;
         job_q        <= job_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         ready_q      <= ready_d;
         done_q       <= done_d;
         bram_we_q    <= bram_we_d;
         bram_addr_q  <= bram_addr_d;
         bram_wdata_q <= bram_wdata_d;
      end
   end

   assign bus.o_job_ready  = ready_q;
   assign bus.o_job_done   = done_q;
   assign bus.o_bram_we    = bram_we_q;
   assign bus.o_bram_addr  = bram_addr_q;
   assign bus.o_bram_wdata = bram_wdata_q;
   assign bus.o_proc_mode  = {24'h0, job_q.mode};
   assign bus.o_proc_param = job_q.param;
   assign bus.o_proc_ready = 1'b1;

endmodule

// File: tb/tb_g2b_job_scheduler.sv
// Directed bench for g2b_job_scheduler: behavioural sources, an add-param
// processor one cycle deep, and a monitor logging BRAM writes and pulses.
module tb_g2b_job_scheduler;
   import g2b_pkg::*;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 256;
   localparam int ADDR_WIDTH = 11;
   localparam int LEN_WIDTH  = 12;

   logic clk = 1'b0;
   logic rst_n;
   logic toggle_en;

   int n_checks = 0;
   int n_errors = 0;

   int          src_idx   [NUM_REQ];
   int          src_limit [NUM_REQ];
   int          wr_addr_q [$];
   logic [63:0] wr_data_q [$];
   int          gnt_q     [$];
   int          done_cnt  [NUM_REQ];
   int          ready_cyc [NUM_REQ];
   int          done_cyc  [NUM_REQ];
   int          done_total;
   int          cyc;
   logic [31:0] seen_mode, seen_param;

   g2b_job_scheduler_if #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)
   ) bus ();

   g2b_job_scheduler #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Source r offers beats (r<<8)+k+1 for k = src_idx[r] while below src_limit[r].
   always_comb begin
      for (int r = 0; r < NUM_REQ; r++) begin
         bus.i_src_valid[r] = (src_idx[r] < src_limit[r]);
         bus.i_src_data[r]  = DATA_WIDTH'((r << 8) + src_idx[r] + 1);
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REQ; r++) src_idx[r] <= 0;
      end else begin
         for (int r = 0; r < NUM_REQ; r++)
            if (bus.o_src_ready[r] && bus.i_src_valid[r]) src_idx[r] <= src_idx[r] + 1;
      end
   end

   // Processor: result = data + param, one cycle after acceptance.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.i_proc_ready <= 1'b1;
         bus.i_proc_valid <= 1'b0;
         bus.i_proc_data  <= '0;
      end else begin
         bus.i_proc_ready <= toggle_en ? ~bus.i_proc_ready : 1'b1;
         bus.i_proc_valid <= bus.o_proc_valid && bus.i_proc_ready;
         bus.i_proc_data  <= bus.o_proc_data + DATA_WIDTH'(bus.o_proc_param);
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         wr_addr_q.delete();
         wr_data_q.delete();
         gnt_q.delete();
         done_total = 0;
         cyc        = 0;
         seen_mode  = '0;
         seen_param = '0;
         for (int r = 0; r < NUM_REQ; r++) begin
            done_cnt[r]  = 0;
            ready_cyc[r] = 0;
            done_cyc[r]  = 0;
         end
      end else begin
         cyc++;
         if (bus.o_bram_we) begin
            wr_addr_q.push_back(int'(bus.o_bram_addr));
            wr_data_q.push_back(64'(bus.o_bram_wdata));
         end
         if (bus.o_proc_valid) begin
            seen_mode  = bus.o_proc_mode;
            seen_param = bus.o_proc_param;
         end
         for (int r = 0; r < NUM_REQ; r++) begin
            if (bus.o_job_ready[r]) begin
               gnt_q.push_back(r);
               ready_cyc[r] = cyc;
            end
            if (bus.o_job_done[r]) begin
               done_cnt[r]++;
               done_total++;
               done_cyc[r] = cyc;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      toggle_en = 1'b0;
      bus.i_job_valid = '0;
      for (int r = 0; r < NUM_REQ; r++) src_limit[r] = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic set_job(input int r, input logic [7:0] mode, input logic [31:0] param,
                          input int len, input int base);
      bus.i_job_mode[r]  = mode;
      bus.i_job_param[r] = param;
      bus.i_job_len[r]   = LEN_WIDTH'(len);
      bus.i_job_base[r]  = ADDR_WIDTH'(base);
      bus.i_job_valid[r] = 1'b1;
   endtask

   // Drop each descriptor once accepted; stop when n_jobs done pulses are logged.
   task automatic serve(input string tag, input int n_jobs, input int budget);
      for (int k = 0; k < budget && done_total < n_jobs; k++) begin
         @(negedge clk);
         for (int r = 0; r < NUM_REQ; r++)
            if (bus.o_job_ready[r]) bus.i_job_valid[r] = 1'b0;
      end
      check({tag, "_done_total"}, 64'(done_total), 64'(n_jobs));
   endtask

   task automatic check_writes(input string tag, input int n, input int base, input logic [63:0] d0);
      check({tag, "_nwr"}, 64'(wr_addr_q.size()), 64'(n));
      for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_q[i]), 64'((base + i) % 2048));
         check($sformatf("%s_data%0d", tag, i), wr_data_q[i], d0 + 64'(i));
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ready"},     64'(bus.o_job_ready),  64'h0);
      check({tag, "_done"},      64'(bus.o_job_done),   64'h0);
      check({tag, "_we"},        64'(bus.o_bram_we),    64'h0);
      check({tag, "_addr"},      64'(bus.o_bram_addr),  64'h0);
      check({tag, "_wdata"},     64'(bus.o_bram_wdata), 64'h0);
      check({tag, "_pvalid"},    64'(bus.o_proc_valid), 64'h0);
      check({tag, "_pdata"},     64'(bus.o_proc_data),  64'h0);
      check({tag, "_src_ready"}, 64'(bus.o_src_ready),  64'h0);
      check({tag, "_mode"},      64'(bus.o_proc_mode),  64'h0);
      check({tag, "_param"},     64'(bus.o_proc_param), 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_g [7];
      int lat;
      exp_g = '{0, 1, 2, 3, 1, 2, 0};

      rst_n = 1'b0;
      toggle_en = 1'b0;
      bus.i_job_valid = '0;
      bus.i_job_mode  = '0;
      bus.i_job_param = '0;
      bus.i_job_len   = '0;
      bus.i_job_base  = '0;
      for (int r = 0; r < NUM_REQ; r++) src_limit[r] = 0;

      // Reset state, with a descriptor already pending.
      set_job(0, MODE_ADD, 32'd5, 4, 'h010);
      src_limit[0] = 8;
      repeat (2) @(negedge clk);
      check_outputs_zero("t0");

      // Single job: data 1..4 plus param 5 to 0x010..0x013.
      apply_reset();
      set_job(0, MODE_ADD, 32'd5, 4, 'h010);
      src_limit[0] = 8;
      serve("t1", 1, 200);
      repeat (4) @(negedge clk);
      check_writes("t1", 4, 'h010, 64'd6);
      check("t1_done0", 64'(done_cnt[0]), 64'd1);
      check("t1_beats", 64'(src_idx[0]), 64'd4);
      check("t1_mode", 64'(seen_mode), 64'h1);
      check("t1_param", 64'(seen_param), 64'd5);

      // Round robin: all four at once, then req1, then req2 and req0 together.
      apply_reset();
      for (int r = 0; r < NUM_REQ; r++) begin
         set_job(r, MODE_ADD, 32'(r), 2, 'h100 + 16 * r);
         src_limit[r] = 16;
      end
      serve("t2a", 4, 300);
      set_job(1, MODE_ADD, 32'd1, 1, 'h180);
      serve("t2b", 5, 200);
      set_job(2, MODE_ADD, 32'd2, 2, 'h190);
      set_job(0, MODE_ADD, 32'd0, 2, 'h1A0);
      serve("t2c", 7, 300);
      repeat (2) @(negedge clk);
      check("t2_ngrants", 64'(gnt_q.size()), 64'd7);
      for (int i = 0; i < 7 && i < gnt_q.size(); i++)
         check($sformatf("t2_grant%0d", i), 64'(gnt_q[i]), 64'(exp_g[i]));
      check("t2_nwr", 64'(wr_addr_q.size()), 64'd13);

      // Zero-length job: accepted and completed, nothing streamed or written.
      apply_reset();
      set_job(1, MODE_PASS, 32'd0, 0, 'h050);
      src_limit[1] = 16;
      serve("t3", 1, 50);
      repeat (3) @(negedge clk);
      lat = done_cyc[1] - ready_cyc[1];
      check("t3_nwr", 64'(wr_addr_q.size()), 64'd0);
      check("t3_done1", 64'(done_cnt[1]), 64'd1);
      check("t3_latency_ok", 64'(lat >= 0 && lat <= 2), 64'd1);
      check("t3_beats", 64'(src_idx[1]), 64'd0);

      // Address wrap at the top of the BRAM.
      apply_reset();
      set_job(0, MODE_ADD, 32'd0, 4, 'h7FE);
      src_limit[0] = 8;
      serve("t4", 1, 200);
      repeat (2) @(negedge clk);
      check_writes("t4", 4, 'h7FE, 64'd1);

      // Processor ready toggling every cycle, eight beats from req3.
      apply_reset();
      toggle_en = 1'b1;
      set_job(3, MODE_ADD, 32'h10, 8, 'h200);
      src_limit[3] = 16;
      serve("t5", 1, 400);
      repeat (2) @(negedge clk);
      check_writes("t5", 8, 'h200, 64'h311);
      check("t5_beats", 64'(src_idx[3]), 64'd8);
      toggle_en = 1'b0;

      // Reset in the middle of a six-beat job.
      apply_reset();
      set_job(1, MODE_ADD, 32'd0, 6, 'h300);
      src_limit[1] = 16;
      for (int k = 0; k < 100 && src_idx[1] < 2; k++) @(negedge clk);
      check("t6_two_beats", 64'(src_idx[1]), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("t6_rst");
      bus.i_job_valid = '0;
      for (int r = 0; r < NUM_REQ; r++) src_limit[r] = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("t6_no_done", 64'(done_total), 64'd0);
      check("t6_no_wr", 64'(wr_addr_q.size()), 64'd0);
      set_job(3, MODE_ADD, 32'd0, 1, 'h000);
      set_job(1, MODE_ADD, 32'd0, 1, 'h008);
      src_limit[1] = 16;
      src_limit[3] = 16;
      serve("t6", 2, 200);
      check("t6_ngrants", 64'(gnt_q.size()), 64'd2);
      if (gnt_q.size() >= 2) begin
         check("t6_grant0", 64'(gnt_q[0]), 64'd1);
         check("t6_grant1", 64'(gnt_q[1]), 64'd3);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/g2b_job_scheduler.md
G2B_JOB_SCHEDULER -- requirements
Module: g2b_job_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters; DATA_WIDTH, default 256, beat width; ADDR_WIDTH, default 11, BRAM word address width; LEN_WIDTH, default 12, job beat-count width.
REQ-002 i_clk  in  1  single clock, all logic rising-edge.
REQ-003 i_reset_n  in  1  asynchronous, active-low reset.
REQ-004 i_job_valid  in  NUM_REQ  per-requester job descriptor valid.
REQ-005 o_job_ready  out  NUM_REQ  one-cycle pulse; descriptor accepted.
REQ-006 i_job_mode  in  NUM_REQ x 8  processing mode per requester.
REQ-007 i_job_param  in  NUM_REQ x 32  mode parameter per requester.
REQ-008 i_job_len  in  NUM_REQ x LEN_WIDTH  beats in job.
REQ-009 i_job_base  in  NUM_REQ x ADDR_WIDTH  BRAM start address.
REQ-010 o_job_done  out  NUM_REQ  one-cycle pulse; last beat of job written.
REQ-011 i_src_data  in  NUM_REQ x DATA_WIDTH  per-requester source beats.
REQ-012 i_src_valid / o_src_ready  in / out  NUM_REQ  per-requester source handshake.
REQ-013 o_proc_data, o_proc_valid, i_proc_ready, o_proc_mode (32), o_proc_param (32)  processor input side.
REQ-014 i_proc_data, i_proc_valid  in  DATA_WIDTH, 1  processor output; o_proc_ready out 1, driven constant 1.
REQ-015 o_bram_we, o_bram_addr, o_bram_wdata  out  1, ADDR_WIDTH, DATA_WIDTH  BRAM write port.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: when any i_job_valid is set, grant the lowest index at or after rr_ptr (round-robin), pulse o_job_ready[g], latch mode/param/len/base, then go to RUN; rr_ptr becomes g+1 mod NUM_REQ.
REQ-018 Latched len == 0: go directly to DONE, with no source beats and no BRAM writes.
REQ-019 RUN: o_proc_data = i_src_data[g], o_proc_valid = i_src_valid[g], o_src_ready[g] = i_proc_ready; all other o_src_ready SHALL be 0.
REQ-020 o_proc_mode = {24'h0, mode}; o_proc_param = param; both SHALL be constant for the whole job.
REQ-021 in_cnt increments on each o_proc_valid && i_proc_ready; when in_cnt reaches len, o_proc_valid and o_src_ready[g] SHALL drop in the next cycle and the FSM goes to DRAIN.
REQ-022 Each i_proc_valid cycle in RUN or DRAIN: o_bram_we=1, o_bram_wdata=i_proc_data, o_bram_addr = base + out_cnt, modulo 2^ADDR_WIDTH (wraps silently); out_cnt then increments.
REQ-023 DRAIN: once out_cnt == len, go to DONE.
REQ-024 DONE: pulse o_job_done[g] for one cycle, clear the counters, return to IDLE. A new grant SHALL occur no earlier than the cycle after DONE.
REQ-025 i_job_valid changes during RUN/DRAIN SHALL be ignored until IDLE; descriptors SHALL be held by requesters until o_job_ready.
REQ-026 Simultaneous requests SHALL be served strictly round-robin; no requester waits more than NUM_REQ-1 jobs.
REQ-027 i_proc_valid outside RUN/DRAIN SHALL NOT produce a BRAM write.

Reset
REQ-028 Asserting reset SHALL force, asynchronously: state=IDLE, rr_ptr=0, counters=0, and all valid/ready/we/done outputs=0; data, address, mode and param outputs = 0.
REQ-029 Reset asserted mid-job SHALL abandon the job with no done pulse; after release, behaviour SHALL be as from power-up.

Structure
REQ-030 A shared package g2b_pkg SHALL hold the FSM state enum, the mode code constants (0x00-0x05, 0xFF) and a job descriptor struct {mode, param, len, base}.
REQ-031 A round-robin arbiter SHALL be a sub-module named g2b_rr_arbiter (request vector, pointer -> one-hot grant); the block totals about 200-300 RTL lines.

Verification
REQ-032 Req0 job {mode=0x01, param=5, len=4, base=0x010}, processor ready always, data 1..4 -> BRAM writes 0x010..0x013 of 6..9, one done[0] pulse.
REQ-033 Req0-3 all valid at once, len=2 each -> grant order 0,1,2,3; a second round with req2,req0 valid -> order 2,0.
REQ-034 len=0 on req1 -> ready[1] pulse, done[1] pulse within 2 cycles, zero BRAM writes.
REQ-035 base=0x7FE, len=4 -> addresses 0x7FE,0x7FF,0x000,0x001.
REQ-036 i_proc_ready toggling 1/0 each cycle, len=8 -> exactly 8 source beats consumed, 8 in-order writes, no duplicates.
REQ-037 Reset asserted after 2 of 6 beats -> outputs zero immediately, no done; next job after release starts at rr_ptr=0.
